// File: rtl/xgmii_rx_engine_if.sv
// Receive FIFO write port of the XGMII receive engine.
//   din   : 72-bit FIFO word {3'b0, err, en_hi, en_lo, last, start, payload[63:0]}
//   wr_en : write strobe, one word per asserted cycle
//   full  : FIFO full, driven by the FIFO
// master = engine side (writer), slave = FIFO side.
interface xgmii_rx_engine_if;
  logic [71:0] din;
  logic        wr_en;
  logic        full;

  modport master (output din, output wr_en, input full);
  modport slave  (input din, input wr_en, output full);
endinterface

// File: rtl/xgmii_rx_engine.sv
// XGMII receive engine for the UDP/IPv4 tunnel.
// Recognises tunnel frames on the 72-bit XGMII receive bus, checks the
// header fields, magic code and FCS, and writes the payload words into the
// receive FIFO in the same 72-bit format the transmit side reads.
// Ports:
//   xgmii_clk     receive clock, all logic on its rising edge
//   sys_rst_n     synchronous active-low reset
//   xgmii_rxd     {rxc[7:0], rxd[63:0]}, lane 0 first on the wire
//   fifo          FIFO write port (din, wr_en, full)
//   if_v4addr     local IPv4 address
//   if_macaddr    local MAC address
//   rx_frame_cnt  accepted frames (wraps)
//   rx_drop_cnt   discarded frames (wraps)
//   rx_err_cnt    accepted or truncated frames whose last word carries err (wraps)
//
// state | meaning
// IDLE  | waiting for the start word, CRC held at its seed
// HDR   | checking header words w1..w6
// DATA  | payload; each word is held back one cycle until the next word is seen
// DROP  | frame rejected, waiting for a terminate character
module xgmii_rx_engine #(
  // Normally overridden with the project-wide tunnel magic code.
  parameter logic [31:0] MAGIC_CODE = 32'h4d41_4743,
  parameter logic [15:0] UDP_PORT   = 16'h0d5e
) (
  input  logic                     xgmii_clk,
  input  logic                     sys_rst_n,
  input  logic [71:0]              xgmii_rxd,
  xgmii_rx_engine_if.master        fifo,
  input  logic [31:0]              if_v4addr,
  input  logic [47:0]              if_macaddr,
  output logic [15:0]              rx_frame_cnt,
  output logic [15:0]              rx_drop_cnt,
  output logic [15:0]              rx_err_cnt
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DROP} state_t;

  localparam logic [63:0] START_D  = 64'hd5555555555555fb;
  localparam logic [31:0] CRC_POLY = 32'hedb88320;

  // Reflected CRC-32, 64 bits per clock, lane 0 first and each byte LSB first.
  function automatic logic [31:0] crc64_next(input logic [31:0] crc, input logic [63:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 64; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ CRC_POLY;
      else             c = c >> 1;
    end
    return c;
  endfunction

  state_t      state_q, state_d;
  logic [71:0] rxd_q;
  logic [2:0]  hidx_q, hidx_d;
  logic [31:0] crc_q, crc_d;
  logic [63:0] hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic        hold_start_q, hold_start_d;
  logic        ovf_q, ovf_d;
  logic [71:0] din_q, din_d;
  logic        wr_en_q, wr_en_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic [7:0]  rxc;
  logic [63:0] rxd;
  logic        is_start;
  logic        is_valid_term;
  logic        has_term;
  logic        fcs_ok;
  logic        hdr_ok;
  logic        frame_err;

  assign rxc = rxd_q[71:64];
  assign rxd = rxd_q[63:0];

  assign is_start      = (rxc == 8'h01) && (rxd == START_D);
  assign is_valid_term = (rxc == 8'hf0) && (rxd[39:32] == 8'hfd) && (rxd[63:40] == 24'h070707);
  // The register is kept in reflected form, so the complemented value is
  // already in wire bit order with CRC byte 0 in lane 0.
  assign fcs_ok        = (rxd[31:0] == ~crc_q);

  always_comb begin
    has_term = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (rxc[k] && (rxd[8*k +: 8] == 8'hfd)) has_term = 1'b1;
    end
  end

  always_comb begin
    hdr_ok = 1'b0;
    case (hidx_q)
      3'd1: begin
        hdr_ok = 1'b1;
        for (int k = 0; k < 6; k++) begin
          if (rxd[8*k +: 8] != if_macaddr[8*(5-k) +: 8]) hdr_ok = 1'b0;
        end
      end
      3'd2: hdr_ok = (rxd[39:32] == 8'h08) && (rxd[47:40] == 8'h00) && (rxd[55:48] == 8'h45);
      3'd3: hdr_ok = (rxd[63:56] == 8'h11);
      3'd4: hdr_ok = (rxd[55:48] == if_v4addr[31:24]) && (rxd[63:56] == if_v4addr[23:16]);
      3'd5: hdr_ok = (rxd[7:0] == if_v4addr[15:8]) && (rxd[15:8] == if_v4addr[7:0]) &&
                     (rxd[39:32] == UDP_PORT[15:8]) && (rxd[47:40] == UDP_PORT[7:0]);
      3'd6: hdr_ok = (rxd[23:16] == MAGIC_CODE[31:24]) && (rxd[31:24] == MAGIC_CODE[23:16]) &&
                     (rxd[39:32] == MAGIC_CODE[15:8])  && (rxd[47:40] == MAGIC_CODE[7:0]);
      default: hdr_ok = 1'b0;
    endcase
    if (rxc != 8'h00) hdr_ok = 1'b0;
  end

  always_comb begin
    state_d      = state_q;
    hidx_d       = hidx_q;
    crc_d        = crc_q;
    hold_d       = hold_q;
    hold_vld_d   = hold_vld_q;
    hold_start_d = hold_start_q;
    ovf_d        = ovf_q;
    din_d        = din_q;
    wr_en_d      = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    err_cnt_d    = err_cnt_q;
    frame_err    = 1'b0;

    case (state_q)
      IDLE: begin
        crc_d = 32'hffffffff;
        if (is_start) begin
          state_d = HDR;
          hidx_d  = 3'd1;
        end
      end

      HDR: begin
        if (hdr_ok) begin
          crc_d = crc64_next(crc_q, rxd);
          if (hidx_q == 3'd6) begin
            state_d    = DATA;
            hold_vld_d = 1'b0;
            ovf_d      = 1'b0;
          end else begin
            hidx_d = hidx_q + 3'd1;
          end
        end else begin
          drop_cnt_d = drop_cnt_q + 16'd1;
          // A word that already terminates the frame leaves nothing to wait for.
          state_d    = has_term ? IDLE : DROP;
        end
      end

      DATA: begin
        if (rxc == 8'h00) begin
          crc_d = crc64_next(crc_q, rxd);
          if (hold_vld_q) begin
            if (fifo.full) begin
              ovf_d = 1'b1;
            end else begin
              wr_en_d = 1'b1;
              din_d   = {3'b000, 1'b0, 2'b11, 1'b0, hold_start_q, hold_q};
            end
          end
          hold_d       = rxd;
          hold_vld_d   = 1'b1;
          hold_start_d = ~hold_vld_q;
        end else if (is_valid_term) begin
          state_d    = IDLE;
          hold_vld_d = 1'b0;
          if (hold_vld_q) begin
            // A last word lost to a full FIFO still marks the frame as errored.
            frame_err   = ~fcs_ok | ovf_q | fifo.full;
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (frame_err) err_cnt_d = err_cnt_q + 16'd1;
            if (!fifo.full) begin
              wr_en_d = 1'b1;
              din_d   = {3'b000, frame_err, 2'b11, 1'b1, hold_start_q, hold_q};
            end
          end else begin
            drop_cnt_d = drop_cnt_q + 16'd1;
          end
        end else begin
          state_d    = has_term ? IDLE : DROP;
          hold_vld_d = 1'b0;
          drop_cnt_d = drop_cnt_q + 16'd1;
          if (hold_vld_q) begin
            // Payload already went out: close it for the consumer, flagged bad.
            err_cnt_d = err_cnt_q + 16'd1;
            if (!fifo.full) begin
              wr_en_d = 1'b1;
              din_d   = {3'b000, 1'b1, 2'b11, 1'b1, hold_start_q, hold_q};
            end
          end
        end
      end

      DROP: begin
        if (has_term) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge xgmii_clk) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      rxd_q        <= '0;
      hidx_q       <= '0;
      crc_q        <= 32'hffffffff;
      hold_q       <= '0;
      hold_vld_q   <= 1'b0;
      hold_start_q <= 1'b0;
      ovf_q        <= 1'b0;
      din_q        <= '0;
      wr_en_q      <= 1'b0;
      frame_cnt_q  <= '0;
      drop_cnt_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      rxd_q        <= xgmii_rxd;
      hidx_q       <= hidx_d;
      crc_q        <= crc_d;
      hold_q       <= hold_d;
      hold_vld_q   <= hold_vld_d;
      hold_start_q <= hold_start_d;
      ovf_q        <= ovf_d;
      din_q        <= din_d;
      wr_en_q      <= wr_en_d;
      frame_cnt_q  <= frame_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign fifo.din     = din_q;
  assign fifo.wr_en   = wr_en_q;
  assign rx_frame_cnt = frame_cnt_q;
  assign rx_drop_cnt  = drop_cnt_q;
  assign rx_err_cnt   = err_cnt_q;

endmodule
